// File: rtl/ifetch.sv
// rtl/ifetch.sv - RISC-V instruction fetch stage with IF/ID register, redirect, halt/drain and misalignment trap.
module ifetch #(
    parameter int          DWIDTH   = 32,
    parameter int          AWIDTH   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              nReset,
    output logic [31:0]       imem_addr,
    input  logic [DWIDTH-1:0] imem_instr,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DWIDTH-1:0] id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    input  logic              halt_req,
    output logic              halted,
    output logic              misaligned_err,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] instr_q, instr_d;
    logic [31:0]       idpc_q, idpc_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;

    logic handshake;
    logic misalign;

    // A redirect flushes the held instruction, so it never counts as a handshake.
    assign handshake = valid_q && id_ready && !redirect;
    assign misalign  = redirect && (redirect_pc[1:0] != 2'b00);

    assign imem_addr = {{(32 - AWIDTH){1'b0}}, pc_q[AWIDTH+1:2]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (handshake) begin
            cnt_d   = cnt_q + 32'd1;
            valid_d = 1'b0;
        end
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            if (misalign) begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_BOOT: begin
                state_d = (halt_req || misalign) ? S_HALT : S_RUN;
            end
            S_RUN: begin
                if (misalign) begin
                    state_d = S_HALT;
                end else if (halt_req) begin
                    state_d = (!valid_q || handshake || redirect) ? S_HALT : S_DRAIN;
                end else if (!redirect && (!valid_q || id_ready)) begin
                    instr_d = imem_instr;
                    idpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            S_DRAIN: begin
                if (redirect || handshake || !valid_q) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (!halt_req && !err_q && !misalign) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            idpc_q   <= 32'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            idpc_q   <= idpc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign id_valid       = valid_q;
    assign id_instr       = instr_q;
    assign id_pc          = idpc_q;
    assign id_pc4         = idpc_q + 32'd4;
    assign halted         = halted_q;
    assign misaligned_err = err_q;
    assign fetch_count    = cnt_q;

endmodule
